// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result source, load size and
// the long-latency holding-buffer state.
package wb_pkg;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    MEM  = 2'd1,
    LINK = 2'd2
  } result_sel_e;

  typedef enum logic [1:0] {
    WORD = 2'd0,
    BYTE = 2'd1,
    HALF = 2'd2
  } load_size_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/load_extract.sv
// Byte/halfword lane select with zero or sign extension for loads.
// Purely combinational; lane indices wrap modulo the number of byte lanes.
module load_extract
  import wb_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int OFF_W = $clog2(WIDTH/8)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       size_i,
  input  logic             signed_i,
  input  logic [OFF_W-1:0] off_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int NL = WIDTH / 8;

  logic [OFF_W-1:0] off_even;
  logic [OFF_W:0]   lo_idx;
  logic [OFF_W:0]   hi_idx;
  logic [OFF_W:0]   byte_idx;
  logic [7:0]       byte_lo;
  logic [7:0]       half_lo;
  logic [7:0]       half_hi;

  always_comb begin
    off_even = off_i & ~(OFF_W'(1));
    byte_idx = (OFF_W+1)'(off_i) % (OFF_W+1)'(NL);
    lo_idx   = (OFF_W+1)'(off_even) % (OFF_W+1)'(NL);
    hi_idx   = ((OFF_W+1)'(off_even) + (OFF_W+1)'(1)) % (OFF_W+1)'(NL);
    byte_lo  = 8'(data_i >> {byte_idx, 3'b000});
    half_lo  = 8'(data_i >> {lo_idx, 3'b000});
    half_hi  = 8'(data_i >> {hi_idx, 3'b000});

    // Fill with the extension bit first, then drop the lane bits on top.
    data_o = data_i;
    case (size_i)
      BYTE: begin
        data_o      = {WIDTH{signed_i & byte_lo[7]}};
        data_o[7:0] = byte_lo;
      end
      HALF: begin
        data_o       = {WIDTH{signed_i & half_hi[7]}};
        data_o[15:0] = {half_hi, half_lo};
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mux2.sv
// Generic 2:1 mux: y = sel ? b : a. Combinational, no latency, no flow control.
module mux2 #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: result select, load extraction and one-entry long-latency buffer.
// One cycle to registered outputs; lu_ready low only while the buffer is FULL.
module write_back_unit
  import wb_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int REG_ADDR_W = 4,
  parameter int OFF_W      = $clog2(WIDTH/8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  reg_write_in,
  input  logic [1:0]            result_sel,
  input  logic [WIDTH-1:0]      alu_result_in,
  input  logic [WIDTH-1:0]      read_data_in,
  input  logic [WIDTH-1:0]      link_in,
  input  logic [1:0]            load_size,
  input  logic                  load_signed,
  input  logic [OFF_W-1:0]      byte_offset,
  input  logic [REG_ADDR_W-1:0] write_register_in,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [WIDTH-1:0]      lu_result,
  input  logic [REG_ADDR_W-1:0] lu_register,
  output logic                  reg_write_out,
  output logic [REG_ADDR_W-1:0] write_register_out,
  output logic [WIDTH-1:0]      result_out
);

  buf_state_e            state_q, state_d;
  logic [REG_ADDR_W-1:0] buf_reg_q, buf_reg_d;
  logic [WIDTH-1:0]      buf_res_q, buf_res_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_register_q, write_register_d;
  logic [WIDTH-1:0]      result_q, result_d;

  logic                  pipe_wr;
  logic [WIDTH-1:0]      mem_data;
  logic [WIDTH-1:0]      pipe_res;
  logic [WIDTH-1:0]      alt_res;
  logic [REG_ADDR_W-1:0] alt_reg;
  logic [WIDTH-1:0]      sel_res;
  logic [REG_ADDR_W-1:0] sel_reg;

  load_extract #(.WIDTH(WIDTH), .OFF_W(OFF_W)) u_load_extract (
    .data_i   (read_data_in),
    .size_i   (load_size),
    .signed_i (load_signed),
    .off_i    (byte_offset),
    .data_o   (mem_data)
  );

  always_comb begin
    case (result_sel)
      MEM:     pipe_res = mem_data;
      LINK:    pipe_res = link_in;
      default: pipe_res = alu_result_in;
    endcase
  end

  // Non-pipeline source: the buffered entry when FULL, else the direct lu offer.
  mux2 #(.W(WIDTH)) u_alt_res (
    .sel(state_q == FULL), .a(lu_result), .b(buf_res_q), .y(alt_res));
  mux2 #(.W(REG_ADDR_W)) u_alt_reg (
    .sel(state_q == FULL), .a(lu_register), .b(buf_reg_q), .y(alt_reg));

  // The pipeline always wins the write port when it has a request.
  mux2 #(.W(WIDTH)) u_sel_res (
    .sel(pipe_wr), .a(alt_res), .b(pipe_res), .y(sel_res));
  mux2 #(.W(REG_ADDR_W)) u_sel_reg (
    .sel(pipe_wr), .a(alt_reg), .b(write_register_in), .y(sel_reg));

  always_comb begin
    pipe_wr          = in_valid & reg_write_in & ~stall & ~flush;
    state_d          = state_q;
    buf_reg_d        = buf_reg_q;
    buf_res_d        = buf_res_q;
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    result_d         = result_q;

    case (state_q)
      EMPTY: begin
        if (pipe_wr || lu_valid) begin
          reg_write_d = 1'b1;
        end
        if (pipe_wr && lu_valid) begin
          buf_reg_d = lu_register;
          buf_res_d = lu_result;
          state_d   = FULL;
        end
      end
      FULL: begin
        reg_write_d = 1'b1;
        // A younger pipeline write to the same register supersedes the buffer.
        if (!pipe_wr || (write_register_in == buf_reg_q)) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (reg_write_d) begin
      write_register_d = sel_reg;
      result_d         = sel_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= EMPTY;
      buf_reg_q        <= '0;
      buf_res_q        <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      result_q         <= '0;
    end else begin
      state_q          <= state_d;
      buf_reg_q        <= buf_reg_d;
      buf_res_q        <= buf_res_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      result_q         <= result_d;
    end
  end

  assign lu_ready           = (state_q == EMPTY);
  assign reg_write_out      = reg_write_q;
  assign write_register_out = write_register_q;
  assign result_out         = result_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Directed, table-driven bench for write_back_unit at WIDTH=24.
module tb_write_back_unit;

  localparam int WIDTH = 24;
  localparam int RW    = 4;
  localparam int OW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, stall, flush, reg_write_in;
  logic [1:0]       result_sel;
  logic [WIDTH-1:0] alu_result_in, read_data_in, link_in;
  logic [1:0]       load_size;
  logic             load_signed;
  logic [OW-1:0]    byte_offset;
  logic [RW-1:0]    write_register_in;
  logic             lu_valid;
  logic             lu_ready;
  logic [WIDTH-1:0] lu_result;
  logic [RW-1:0]    lu_register;
  logic             reg_write_out;
  logic [RW-1:0]    write_register_out;
  logic [WIDTH-1:0] result_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  write_back_unit #(.WIDTH(WIDTH), .REG_ADDR_W(RW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .stall              (stall),
    .flush              (flush),
    .reg_write_in       (reg_write_in),
    .result_sel         (result_sel),
    .alu_result_in      (alu_result_in),
    .read_data_in       (read_data_in),
    .link_in            (link_in),
    .load_size          (load_size),
    .load_signed        (load_signed),
    .byte_offset        (byte_offset),
    .write_register_in  (write_register_in),
    .lu_valid           (lu_valid),
    .lu_ready           (lu_ready),
    .lu_result          (lu_result),
    .lu_register        (lu_register),
    .reg_write_out      (reg_write_out),
    .write_register_out (write_register_out),
    .result_out         (result_out)
  );

  typedef struct {
    logic [1:0]       sel;
    logic [1:0]       size;
    logic             sgn;
    logic [OW-1:0]    off;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] lnk;
    logic             iv, st, fl, rw;
    logic [RW-1:0]    wreg;
    logic             e_we;
    logic [RW-1:0]    e_reg;
    logic [WIDTH-1:0] e_res;
  } vec_t;

  vec_t vec [16];

  function automatic vec_t mkv(logic [1:0] sel, logic [1:0] size, logic sgn,
                               logic [OW-1:0] off, logic [WIDTH-1:0] alu,
                               logic [WIDTH-1:0] lnk, logic iv, logic st,
                               logic fl, logic rw, logic [RW-1:0] wreg,
                               logic e_we, logic [RW-1:0] e_reg,
                               logic [WIDTH-1:0] e_res);
    vec_t v;
    v.sel = sel; v.size = size; v.sgn = sgn; v.off = off;
    v.alu = alu; v.lnk = lnk; v.iv = iv; v.st = st; v.fl = fl; v.rw = rw;
    v.wreg = wreg; v.e_we = e_we; v.e_reg = e_reg; v.e_res = e_res;
    return v;
  endfunction

  task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; reg_write_in = 0;
    result_sel = 2'd0; alu_result_in = 24'h111111; read_data_in = 24'h12F480;
    link_in = 24'h222222; load_size = 2'd0; load_signed = 0; byte_offset = '0;
    write_register_in = '0; lu_valid = 0; lu_result = '0; lu_register = '0;
  endtask

  task automatic pipe_alu(logic [RW-1:0] r, logic [WIDTH-1:0] v);
    in_valid = 1; reg_write_in = 1; result_sel = 2'd0;
    alu_result_in = v; write_register_in = r;
  endtask

  task automatic offer_lu(logic [RW-1:0] r, logic [WIDTH-1:0] v);
    lu_valid = 1; lu_register = r; lu_result = v;
  endtask

  // Launch a cycle at the falling edge, sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic out_chk(string name, logic we, logic [RW-1:0] r, logic [WIDTH-1:0] v);
    chk({name, "_we"}, WIDTH'(reg_write_out), WIDTH'(we));
    chk({name, "_reg"}, WIDTH'(write_register_out), WIDTH'(r));
    chk({name, "_res"}, result_out, v);
  endtask

  initial begin
    //            sel   size  sgn off alu        link       iv st fl rw wr   we reg  result
    vec[0]  = mkv(2'd1, 2'd1, 1, 1, 24'h111111, 24'h222222, 1, 0, 0, 1, 2,  1, 2,  24'hFFFFF4);
    vec[1]  = mkv(2'd1, 2'd1, 0, 1, 24'h111111, 24'h222222, 1, 0, 0, 1, 2,  1, 2,  24'h0000F4);
    vec[2]  = mkv(2'd1, 2'd2, 1, 1, 24'h111111, 24'h222222, 1, 0, 0, 1, 4,  1, 4,  24'hFFF480);
    vec[3]  = mkv(2'd1, 2'd2, 0, 1, 24'h111111, 24'h222222, 1, 0, 0, 1, 4,  1, 4,  24'h00F480);
    vec[4]  = mkv(2'd1, 2'd0, 1, 1, 24'h111111, 24'h222222, 1, 0, 0, 1, 6,  1, 6,  24'h12F480);
    vec[5]  = mkv(2'd1, 2'd1, 1, 0, 24'h111111, 24'h222222, 1, 0, 0, 1, 1,  1, 1,  24'hFFFF80);
    vec[6]  = mkv(2'd1, 2'd1, 1, 2, 24'h111111, 24'h222222, 1, 0, 0, 1, 1,  1, 1,  24'h000012);
    vec[7]  = mkv(2'd1, 2'd1, 1, 3, 24'h111111, 24'h222222, 1, 0, 0, 1, 1,  1, 1,  24'hFFFF80);
    vec[8]  = mkv(2'd0, 2'd1, 1, 1, 24'h123456, 24'h222222, 1, 0, 0, 1, 8,  1, 8,  24'h123456);
    vec[9]  = mkv(2'd2, 2'd1, 1, 1, 24'h111111, 24'hABCDEF, 1, 0, 0, 1, 9,  1, 9,  24'hABCDEF);
    vec[10] = mkv(2'd3, 2'd1, 1, 1, 24'h00BEEF, 24'h222222, 1, 0, 0, 1, 10, 1, 10, 24'h00BEEF);
    vec[11] = mkv(2'd0, 2'd0, 0, 0, 24'h333333, 24'h222222, 1, 1, 0, 1, 11, 0, 10, 24'h00BEEF);
    vec[12] = mkv(2'd0, 2'd0, 0, 0, 24'h444444, 24'h222222, 1, 0, 1, 1, 12, 0, 10, 24'h00BEEF);
    vec[13] = mkv(2'd0, 2'd0, 0, 0, 24'h555555, 24'h222222, 0, 0, 0, 1, 13, 0, 10, 24'h00BEEF);
    vec[14] = mkv(2'd0, 2'd0, 0, 0, 24'h666666, 24'h222222, 1, 0, 0, 0, 14, 0, 10, 24'h00BEEF);
    vec[15] = mkv(2'd2, 2'd0, 0, 0, 24'h111111, 24'h000777, 1, 0, 0, 1, 15, 1, 15, 24'h000777);

    idle();
    rst_n = 0;
    #12;
    out_chk("reset", 0, 0, 0);
    chk("reset_lu_ready", WIDTH'(lu_ready), 24'd1);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      result_sel = vec[i].sel; load_size = vec[i].size; load_signed = vec[i].sgn;
      byte_offset = vec[i].off; alu_result_in = vec[i].alu; link_in = vec[i].lnk;
      in_valid = vec[i].iv; stall = vec[i].st; flush = vec[i].fl;
      reg_write_in = vec[i].rw; write_register_in = vec[i].wreg;
      step();
      out_chk($sformatf("vec%0d", i), vec[i].e_we, vec[i].e_reg, vec[i].e_res);
    end

    // P and lu collide: lu is buffered and written on the first free cycle.
    @(negedge clk); idle(); pipe_alu(3, 24'h000010); offer_lu(5, 24'h0000AA);
    chk("collide_lu_ready_before", WIDTH'(lu_ready), 24'd1);
    step();
    out_chk("collide_n1", 1, 3, 24'h000010);
    chk("collide_lu_ready_n1", WIDTH'(lu_ready), 24'd0);
    @(negedge clk); idle();
    step();
    out_chk("collide_n2", 1, 5, 24'h0000AA);
    @(negedge clk); idle();
    step();
    chk("collide_we_n3", WIDTH'(reg_write_out), 24'd0);
    chk("collide_lu_ready_n3", WIDTH'(lu_ready), 24'd1);

    // Direct lu transfer while EMPTY.
    @(negedge clk); idle(); offer_lu(11, 24'h5A5A5A);
    step();
    out_chk("direct_lu", 1, 11, 24'h5A5A5A);
    chk("direct_lu_ready", WIDTH'(lu_ready), 24'd1);

    // FULL, P to another register keeps the buffer; a stalled slot lets it drain.
    @(negedge clk); idle(); pipe_alu(3, 24'h000030); offer_lu(5, 24'h0000CC);
    step();
    @(negedge clk); idle(); pipe_alu(6, 24'h000066);
    step();
    out_chk("full_other", 1, 6, 24'h000066);
    chk("full_other_lu_ready", WIDTH'(lu_ready), 24'd0);
    @(negedge clk); idle(); pipe_alu(7, 24'h000077); stall = 1;
    step();
    out_chk("full_stall_drain", 1, 5, 24'h0000CC);
    chk("full_stall_lu_ready", WIDTH'(lu_ready), 24'd1);

    // FULL, P to the buffered register drops the older buffered entry.
    @(negedge clk); idle(); pipe_alu(3, 24'h000031); offer_lu(5, 24'h0000BB);
    step();
    @(negedge clk); idle(); pipe_alu(5, 24'h000007);
    step();
    out_chk("drop", 1, 5, 24'h000007);
    chk("drop_lu_ready", WIDTH'(lu_ready), 24'd1);
    @(negedge clk); idle();
    step();
    out_chk("drop_after", 0, 5, 24'h000007);

    // Asynchronous reset while FULL.
    @(negedge clk); idle(); pipe_alu(4, 24'h000044); offer_lu(9, 24'h000099);
    step();
    chk("prereset_lu_ready", WIDTH'(lu_ready), 24'd0);
    @(negedge clk); idle();
    #1 rst_n = 0;
    #1;
    out_chk("async_reset", 0, 0, 0);
    chk("async_reset_lu_ready", WIDTH'(lu_ready), 24'd1);
    @(negedge clk); rst_n = 1;
    step();
    out_chk("post_reset1", 0, 0, 0);
    @(negedge clk);
    step();
    out_chk("post_reset2", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
